// File: rtl/gx_reconfig_master.sv
// gx_reconfig_master: Avalon-MM initiator for transceiver dynamic reconfiguration.
// Runs one read / write / masked read-modify-write at a time, holding off while calibration is busy.
module gx_reconfig_master #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              reconfig_clk,
    input  logic              reconfig_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_mask,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    input  logic              cal_busy,
    output logic              reconfig_read,
    output logic              reconfig_write,
    output logic [ADDR_W-1:0] reconfig_address,
    output logic [DATA_W-1:0] reconfig_writedata,
    input  logic [DATA_W-1:0] reconfig_readdata,
    input  logic              reconfig_waitrequest
);
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      OP_RD    = 2'b00;
    localparam logic [1:0]      OP_WR    = 2'b01;
    localparam logic [1:0]      OP_RMW   = 2'b10;

    typedef enum logic [2:0] {IDLE, WAIT_CAL, RD, WR, RESP} state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_mask;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_cal_s1;
    logic                r_cal_s2;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_error;
    logic                r_read;
    logic                r_write;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_writedata;

    logic                w_timeout;
    logic [DATA_W-1:0]   w_merged;

    assign w_timeout = ((r_state == WAIT_CAL) || (r_state == RD) || (r_state == WR))
                       && (r_cnt == CNT_LAST);
    assign w_merged  = (reconfig_readdata & ~r_mask) | (r_wdata & r_mask);

    assign cmd_ready          = r_cmd_ready;
    assign rsp_valid          = r_rsp_valid;
    assign rsp_rdata          = r_rsp_rdata;
    assign rsp_error          = r_rsp_error;
    assign reconfig_read      = r_read;
    assign reconfig_write     = r_write;
    assign reconfig_address   = r_address;
    assign reconfig_writedata = r_writedata;

    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_addr      <= '0;
            r_mask      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_cal_s1    <= 1'b0;
            r_cal_s2    <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_address   <= '0;
            r_writedata <= '0;
        end else begin
            r_cal_s1 <= cal_busy;
            r_cal_s2 <= r_cal_s1;
            // Timeout takes priority over any completion seen in the same cycle.
            if (w_timeout) begin
                r_read      <= 1'b0;
                r_write     <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_error <= 1'b1;
                r_rsp_rdata <= '0;
                r_state     <= RESP;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cmd_ready <= 1'b1;
                        if (cmd_valid && r_cmd_ready) begin
                            r_cmd_ready <= 1'b0;
                            r_op        <= cmd_op;
                            r_addr      <= cmd_address;
                            r_mask      <= cmd_mask;
                            r_wdata     <= cmd_wdata;
                            r_cnt       <= '0;
                            if (cmd_op == 2'b11) begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_error <= 1'b1;
                                r_rsp_rdata <= '0;
                                r_state     <= RESP;
                            end else begin
                                r_state <= WAIT_CAL;
                            end
                        end
                    end
                    WAIT_CAL: begin
                        if (!r_cal_s2) begin
                            r_cnt     <= '0;
                            r_address <= r_addr;
                            if (r_op == OP_WR) begin
                                r_write     <= 1'b1;
                                r_writedata <= r_wdata;
                                r_state     <= WR;
                            end else begin
                                r_read  <= 1'b1;
                                r_state <= RD;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    RD: begin
                        if (!reconfig_waitrequest) begin
                            r_read <= 1'b0;
                            if (r_op == OP_RMW) begin
                                r_cnt       <= '0;
                                r_write     <= 1'b1;
                                r_writedata <= w_merged;
                                r_state     <= WR;
                            end else begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_error <= 1'b0;
                                r_rsp_rdata <= reconfig_readdata;
                                r_state     <= RESP;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    WR: begin
                        if (!reconfig_waitrequest) begin
                            r_write     <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b0;
                            r_rsp_rdata <= r_writedata;
                            r_state     <= RESP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    RESP: begin
                        if (rsp_ready) begin
                            r_rsp_valid <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gx_reconfig_master.sv
// Directed bench for gx_reconfig_master: Avalon slave model plus a response scoreboard.
// A second instance with a short timeout exercises the stuck-waitrequest abort.
module tb_gx_reconfig_master;

    logic        reconfig_clk = 1'b0;
    logic        reconfig_reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_valid_t = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [9:0]  cmd_address = '0;
    logic [31:0] cmd_mask = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        cal_busy = 1'b0;
    logic [31:0] reconfig_readdata = '0;
    logic        reconfig_waitrequest = 1'b1;
    logic [31:0] readdata_t = '0;
    logic        waitrequest_t = 1'b1;

    logic        cmd_ready, rsp_valid, rsp_error, reconfig_read, reconfig_write;
    logic [31:0] rsp_rdata, reconfig_writedata;
    logic [9:0]  reconfig_address;
    logic        cmd_ready_t, rsp_valid_t, rsp_error_t, read_t, write_t;
    logic [31:0] rsp_rdata_t, writedata_t;
    logic [9:0]  address_t;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t sb_q[$];

    // Slave model configuration (written by the stimulus) and observations (written by the slave).
    int          slave_wait = 0;
    logic [31:0] mem_rdata = '0;
    int          stall_left = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    int          rd_t_cycles = 0;
    logic        both_seen = 1'b0;
    logic [9:0]  last_raddr = '0;
    logic [9:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;

    always #5 reconfig_clk = ~reconfig_clk;

    gx_reconfig_master #(
        .ADDR_W(10), .DATA_W(32), .TIMEOUT_CYCLES(1024)
    ) dut (
        .reconfig_clk(reconfig_clk), .reconfig_reset_n(reconfig_reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_address(cmd_address), .cmd_mask(cmd_mask), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .cal_busy(cal_busy),
        .reconfig_read(reconfig_read), .reconfig_write(reconfig_write),
        .reconfig_address(reconfig_address), .reconfig_writedata(reconfig_writedata),
        .reconfig_readdata(reconfig_readdata), .reconfig_waitrequest(reconfig_waitrequest)
    );

    gx_reconfig_master #(
        .ADDR_W(10), .DATA_W(32), .TIMEOUT_CYCLES(16)
    ) dut_to (
        .reconfig_clk(reconfig_clk), .reconfig_reset_n(reconfig_reset_n),
        .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t), .cmd_op(cmd_op),
        .cmd_address(cmd_address), .cmd_mask(cmd_mask), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_t),
        .rsp_error(rsp_error_t), .cal_busy(cal_busy),
        .reconfig_read(read_t), .reconfig_write(write_t),
        .reconfig_address(address_t), .reconfig_writedata(writedata_t),
        .reconfig_readdata(readdata_t), .reconfig_waitrequest(waitrequest_t)
    );

    always @(negedge reconfig_clk) begin
        if (reconfig_read && reconfig_write) both_seen = 1'b1;
        if (reconfig_read)  rd_cycles++;
        if (reconfig_write) wr_cycles++;
        if (read_t)         rd_t_cycles++;
        if (reconfig_read || reconfig_write) begin
            if (stall_left > 0) begin
                reconfig_waitrequest = 1'b1;
                stall_left--;
            end else begin
                reconfig_waitrequest = 1'b0;
                reconfig_readdata    = mem_rdata;
                if (reconfig_read) last_raddr = reconfig_address;
                if (reconfig_write) begin
                    last_waddr = reconfig_address;
                    last_wdata = reconfig_writedata;
                end
                stall_left = slave_wait;
            end
        end else begin
            reconfig_waitrequest = 1'b1;
            stall_left           = slave_wait;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge reconfig_clk);
            #2;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [9:0] addr, input logic [31:0] mask,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        rsp_t e;
        for (int i = 0; i < 100 && cmd_ready !== 1'b1; i++) step(1);
        chk("cmd_ready_before_send", {31'b0, cmd_ready}, 32'd1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_address = addr;
        cmd_mask    = mask;
        cmd_wdata   = wd;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb_q.push_back(e);
        step(1);
        cmd_valid = 1'b0;
        chk("cmd_ready_after_accept", {31'b0, cmd_ready}, 32'd0);
    endtask

    // Wait for a response, compare with the scoreboard head, optionally stall, then consume it.
    task automatic collect(input int exp_lat, input int hold);
        rsp_t e;
        int   cyc;
        e.rdata = '0;
        e.err   = 1'b0;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 2000) begin
            step(1);
            cyc++;
        end
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        if (exp_lat >= 0) chk("latency", cyc, exp_lat);
        if (sb_q.size() == 0) chk("scoreboard_nonempty", 32'd0, 32'd1);
        else e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_error", {31'b0, rsp_error}, {31'b0, e.err});
        for (int i = 0; i < hold; i++) begin
            step(1);
            chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, e.rdata);
            chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        chk("rsp_valid_dropped", {31'b0, rsp_valid}, 32'd0);
        chk("cmd_ready_after_rsp", {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int rd0, wr0, cyc;

        // Reset state
        step(3);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_strobes", {30'b0, reconfig_read, reconfig_write}, 32'd0);
        chk("rst_address", {22'b0, reconfig_address}, 32'd0);
        chk("rst_writedata", reconfig_writedata, 32'd0);
        chk("rst_rsp", {rsp_rdata[30:0], rsp_error}, 32'd0);
        reconfig_reset_n = 1'b1;
        #1;
        chk("cmd_ready_before_first_edge", {31'b0, cmd_ready}, 32'd0);
        #1;
        step(1);
        chk("cmd_ready_after_release", {31'b0, cmd_ready}, 32'd1);
        chk("cmd_ready_t_after_release", {31'b0, cmd_ready_t}, 32'd1);

        // Best-case read
        slave_wait = 0;
        mem_rdata  = 32'hA5A5_0001;
        rd0 = rd_cycles;
        send(2'b00, 10'h111, '0, '0, 32'hA5A5_0001, 1'b0);
        collect(2, 0);
        chk("bestcase_read_cycles", rd_cycles - rd0, 32'd1);

        // Read with three stalled cycles
        slave_wait = 3;
        mem_rdata  = 32'h1234_5678;
        rd0 = rd_cycles;
        send(2'b00, 10'h0A6, '0, '0, 32'h1234_5678, 1'b0);
        collect(-1, 0);
        chk("read_strobe_cycles", rd_cycles - rd0, 32'd4);
        chk("read_address", {22'b0, last_raddr}, 32'h0A6);

        // Best-case write
        slave_wait = 0;
        send(2'b01, 10'h3FF, '0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        collect(2, 0);
        chk("write_address", {22'b0, last_waddr}, 32'h3FF);
        chk("write_data", last_wdata, 32'hDEAD_BEEF);
        chk("address_held_idle", {22'b0, reconfig_address}, 32'h3FF);

        // Best-case RMW
        mem_rdata = 32'hFFFF_FF0F;
        send(2'b10, 10'h007, 32'h0000_00F0, 32'h0000_0050, 32'hFFFF_FF5F, 1'b0);
        collect(3, 0);
        chk("rmw_read_address", {22'b0, last_raddr}, 32'h007);
        chk("rmw_write_address", {22'b0, last_waddr}, 32'h007);
        chk("rmw_write_data", last_wdata, 32'hFFFF_FF5F);

        // RMW with stalls on both accesses
        slave_wait = 2;
        mem_rdata  = 32'h1234_5678;
        send(2'b10, 10'h2C3, 32'hFFFF_0000, 32'hABCD_0000, 32'hABCD_5678, 1'b0);
        collect(-1, 0);
        chk("rmw2_write_data", last_wdata, 32'hABCD_5678);

        // Write held off by calibration
        slave_wait = 0;
        cal_busy   = 1'b1;
        step(3);
        wr0 = wr_cycles;
        send(2'b01, 10'h123, '0, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0);
        step(20);
        chk("cal_no_strobe", wr_cycles - wr0, 32'd0);
        cal_busy = 1'b0;
        step(1);
        chk("cal_fall_edge1", {31'b0, reconfig_write}, 32'd0);
        step(1);
        chk("cal_fall_edge2", {31'b0, reconfig_write}, 32'd0);
        step(1);
        chk("cal_fall_edge3", {31'b0, reconfig_write}, 32'd1);
        collect(-1, 0);
        chk("cal_write_data", last_wdata, 32'hCAFE_BABE);

        // Reserved op, response stalled for five cycles
        rd0 = rd_cycles;
        wr0 = wr_cycles;
        send(2'b11, 10'h055, '0, 32'h1111_1111, 32'h0, 1'b1);
        collect(0, 5);
        chk("reserved_no_strobe", (rd_cycles - rd0) + (wr_cycles - wr0), 32'd0);

        // Stuck waitrequest on the short-timeout instance
        waitrequest_t = 1'b1;
        rd0 = rd_t_cycles;
        cmd_op      = 2'b00;
        cmd_address = 10'h0A0;
        cmd_valid_t = 1'b1;
        step(1);
        cmd_valid_t = 1'b0;
        cyc = 0;
        while (rsp_valid_t !== 1'b1 && cyc < 100) begin
            step(1);
            cyc++;
        end
        chk("to_rsp_valid", {31'b0, rsp_valid_t}, 32'd1);
        chk("to_rsp_error", {31'b0, rsp_error_t}, 32'd1);
        chk("to_rsp_rdata", rsp_rdata_t, 32'd0);
        chk("to_read_cycles", rd_t_cycles - rd0, 32'd16);
        chk("to_read_dropped", {31'b0, read_t}, 32'd0);
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        chk("to_cmd_ready", {31'b0, cmd_ready_t}, 32'd1);
        waitrequest_t = 1'b0;
        readdata_t    = 32'h5555_AAAA;
        cmd_valid_t   = 1'b1;
        step(1);
        cmd_valid_t = 1'b0;
        cyc = 0;
        while (rsp_valid_t !== 1'b1 && cyc < 100) begin
            step(1);
            cyc++;
        end
        chk("to_next_rsp_valid", {31'b0, rsp_valid_t}, 32'd1);
        chk("to_next_rsp_error", {31'b0, rsp_error_t}, 32'd0);
        chk("to_next_rsp_rdata", rsp_rdata_t, 32'h5555_AAAA);
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;

        // Reset in the middle of a stalled write
        slave_wait = 50;
        send(2'b01, 10'h055, '0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
        for (int i = 0; i < 20 && reconfig_write !== 1'b1; i++) step(1);
        chk("midwrite_strobe", {31'b0, reconfig_write}, 32'd1);
        reconfig_reset_n = 1'b0;
        #1;
        chk("reset_async_write", {31'b0, reconfig_write}, 32'd0);
        chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        void'(sb_q.pop_back());
        #1;
        step(2);
        reconfig_reset_n = 1'b1;
        step(1);
        chk("reset_release_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        step(3);
        chk("reset_no_rsp", {31'b0, rsp_valid}, 32'd0);

        // Normal operation after reset
        slave_wait = 0;
        mem_rdata  = 32'h0F0F_F0F0;
        send(2'b00, 10'h001, '0, '0, 32'h0F0F_F0F0, 1'b0);
        collect(2, 0);

        chk("strobes_never_both", {31'b0, both_seen}, 32'd0);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
